// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch, MMU and L2 line signals of the set-associative I-cache
interface icache_assoc_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS * 4);
  localparam int LINE_W = BLOCK_WORDS * 32;

  logic [ADDR_WIDTH-1:0]       addr;
  logic [ADDR_WIDTH-1:0]       addr_vir;
  logic                        addr_valid;
  logic                        page_fault;
  logic                        access_fault;
  logic                        flush;
  logic                        dcache_flushing;
  logic                        cache_ready;
  logic [DATA_WIDTH-1:0]       data;
  logic                        data_valid;
  logic [ADDR_WIDTH-1:0]       addr_out;
  logic                        page_fault_out;
  logic                        access_fault_out;
  logic                        addr_to_l2_valid;
  logic [ADDR_WIDTH-OFF_W-1:0] addr_to_l2;
  logic [LINE_W-1:0]           data_from_l2;
  logic                        data_from_l2_valid;

  modport slave (
    input  addr, addr_vir, addr_valid, page_fault, access_fault, flush, dcache_flushing,
           data_from_l2, data_from_l2_valid,
    output cache_ready, data, data_valid, addr_out, page_fault_out, access_fault_out,
           addr_to_l2_valid, addr_to_l2
  );

  modport master (
    output addr, addr_vir, addr_valid, page_fault, access_fault, flush, dcache_flushing,
           data_from_l2, data_from_l2_valid,
    input  cache_ready, data, data_valid, addr_out, page_fault_out, access_fault_out,
           addr_to_l2_valid, addr_to_l2
  );
endinterface

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative I-cache, round-robin victim, one-cycle flush
module icache_assoc #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int SETS        = 128,
  parameter int WAYS        = 4
) (
  input  logic           clk,
  input  logic           rst,
  icache_assoc_if.slave  bus
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS * 4);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int LINE_W = BLOCK_WORDS * 32;
  localparam int WRD_W  = $clog2(BLOCK_WORDS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  state_t                  state, state_nxt;
  logic                    flush_pend, flush_pend_nxt;
  logic                    s_valid, s_pf, s_af;
  logic [ADDR_WIDTH-1:0]   s_addr, s_vir;
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAY_W-1:0]        rr_q [SETS];
  logic [TAG_W-1:0]        tag_mem [WAYS][SETS];
  logic [LINE_W-1:0]       data_mem [WAYS][SETS];
  logic [TAG_W-1:0]        rd_tag [WAYS];
  logic [LINE_W-1:0]       rd_data [WAYS];
  logic [LINE_W-1:0]       fill_line, hit_line;
  logic [ADDR_WIDTH-OFF_W-1:0] l2_addr_q;

  logic [IDX_W-1:0]        a_idx, s_idx;
  logic [TAG_W-1:0]        s_tag;
  logic [WRD_W-1:0]        s_wrd;
  logic [WAYS-1:0]         hit_vec;
  logic                    s_fault, s_hit, s_miss;
  logic [WAY_W-1:0]        victim, rr_inc;
  logic                    use_rr;
  logic                    ready, dv, accept, l2_req, fill_we, flush_apply, s_kill, l2_take;
  logic [DATA_WIDTH-1:0]   out_word;

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [LINE_W-1:0] line,
                                                 input logic [WRD_W-1:0] wrd);
    return DATA_WIDTH'(line >> {wrd, 5'd0});
  endfunction

  assign a_idx   = bus.addr[OFF_W +: IDX_W];
  assign s_idx   = s_addr[OFF_W +: IDX_W];
  assign s_tag   = s_addr[ADDR_WIDTH-1 -: TAG_W];
  assign s_wrd   = s_addr[2 +: WRD_W];
  assign s_fault = s_pf | s_af;

  always_comb begin
    hit_vec  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[s_idx][w] && (rd_tag[w] == s_tag);
      if (hit_vec[w]) hit_line = hit_line | rd_data[w];
    end
  end

  assign s_hit  = s_valid & (s_fault | (|hit_vec));
  assign s_miss = s_valid & ~s_fault & ~(|hit_vec);

  // Invalid ways take priority; the pointer only moves when it actually chose the victim.
  always_comb begin
    victim = rr_q[s_idx];
    use_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[s_idx][w]) begin
        victim = WAY_W'(w);
        use_rr = 1'b0;
      end
    end
    rr_inc = WAY_W'((32'(rr_q[s_idx]) + 1) % WAYS);
  end

  always_comb begin
    state_nxt      = state;
    flush_pend_nxt = flush_pend;
    ready          = 1'b0;
    dv             = 1'b0;
    out_word       = '0;
    l2_req         = 1'b0;
    fill_we        = 1'b0;
    flush_apply    = 1'b0;
    s_kill         = 1'b0;
    l2_take        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.flush) begin
          flush_apply = 1'b1;
          s_kill      = 1'b1;
        end else begin
          ready = ~s_miss;
          dv    = s_hit;
          if (s_hit && !s_fault) out_word = pick(hit_line, s_wrd);
          if (s_miss) state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.flush) begin
          flush_apply = 1'b1;
          s_kill      = 1'b1;
          state_nxt   = S_IDLE;
        end else if (!bus.dcache_flushing) begin
          l2_req    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.data_from_l2_valid) begin
          if (flush_pend || bus.flush) begin
            flush_apply    = 1'b1;
            s_kill         = 1'b1;
            flush_pend_nxt = 1'b0;
            state_nxt      = S_IDLE;
          end else begin
            l2_take   = 1'b1;
            state_nxt = S_FILL;
          end
        end else if (bus.flush) begin
          flush_pend_nxt = 1'b1;
        end
      end
      S_FILL: begin
        state_nxt = S_IDLE;
        if (bus.flush) begin
          flush_apply = 1'b1;
          s_kill      = 1'b1;
        end else begin
          fill_we  = 1'b1;
          ready    = 1'b1;
          dv       = 1'b1;
          out_word = pick(fill_line, s_wrd);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = bus.addr_valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      s_valid    <= 1'b0;
      s_addr     <= '0;
      s_vir      <= '0;
      s_pf       <= 1'b0;
      s_af       <= 1'b0;
      fill_line  <= '0;
      l2_addr_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
      if (accept) begin
        s_valid <= 1'b1;
        s_addr  <= bus.addr;
        s_vir   <= bus.addr_vir;
        s_pf    <= bus.page_fault;
        s_af    <= bus.access_fault;
      end else if (ready || s_kill) begin
        s_valid <= 1'b0;
      end
      if (l2_take) fill_line <= bus.data_from_l2;
      if (state == S_IDLE && state_nxt == S_REQ) l2_addr_q <= s_addr[ADDR_WIDTH-1:OFF_W];
      if (flush_apply) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else if (fill_we) begin
        valid_q[s_idx][victim] <= 1'b1;
        if (use_rr) rr_q[s_idx] <= rr_inc;
      end
    end
  end

  // A request accepted in FILL may read the set being written; forward the new line.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[victim][s_idx]  <= s_tag;
      data_mem[victim][s_idx] <= fill_line;
    end
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        if (fill_we && victim == WAY_W'(w) && a_idx == s_idx) begin
          rd_tag[w]  <= s_tag;
          rd_data[w] <= fill_line;
        end else begin
          rd_tag[w]  <= tag_mem[w][a_idx];
          rd_data[w] <= data_mem[w][a_idx];
        end
      end
    end
  end

  a_onehot_hit: assert property (@(posedge clk) disable iff (rst)
    (s_valid && state == S_IDLE) |-> $onehot0(hit_vec));

  assign bus.cache_ready      = ready;
  assign bus.data_valid       = dv;
  assign bus.data             = out_word;
  assign bus.addr_out         = dv ? s_vir : '0;
  assign bus.page_fault_out   = dv & s_pf;
  assign bus.access_fault_out = dv & s_af;
  assign bus.addr_to_l2_valid = l2_req;
  assign bus.addr_to_l2       = l2_addr_q;
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed self-checking bench for icache_assoc
module tb_icache_assoc;
  localparam logic [31:0] K    = 32'hC0DE_0000;
  localparam logic [31:0] VBIT = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  icache_assoc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(16)) bus ();

  icache_assoc #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WORDS(16), .SETS(128), .WAYS(4))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [511:0] line_for(input logic [25:0] la);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = {la, 4'(i), 2'b00} ^ K;
    return l;
  endfunction

  task automatic issue(input logic [31:0] a, input logic pf);
    bus.addr       = a;
    bus.addr_vir   = a | VBIT;
    bus.page_fault = pf;
    bus.addr_valid = 1'b1;
    cyc();
    bus.addr_valid = 1'b0;
    bus.page_fault = 1'b0;
    smp();
  endtask

  task automatic wait_pulse(input string tag, input logic [31:0] a);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      cyc();
      smp();
      n++;
      if (bus.addr_to_l2_valid) seen = 1'b1;
    end
    chk({tag, ".pulse_seen"}, seen, 1'b1);
    chk({tag, ".l2_addr"}, bus.addr_to_l2, a >> 6);
  endtask

  task automatic fetch_miss(input string tag, input logic [31:0] a);
    int pulses = 1;
    issue(a, 1'b0);
    chk({tag, ".miss_ready"}, bus.cache_ready, 1'b0);
    chk({tag, ".miss_dv"}, bus.data_valid, 1'b0);
    wait_pulse(tag, a);
    repeat (2) begin
      cyc();
      smp();
      pulses += int'(bus.addr_to_l2_valid);
    end
    cyc();
    bus.data_from_l2       = line_for(a[31:6]);
    bus.data_from_l2_valid = 1'b1;
    smp();
    pulses += int'(bus.addr_to_l2_valid);
    chk({tag, ".pulse_count"}, pulses, 1);
    cyc();
    bus.data_from_l2_valid = 1'b0;
    smp();
    chk({tag, ".fill_dv"}, bus.data_valid, 1'b1);
    chk({tag, ".fill_data"}, bus.data, a ^ K);
    chk({tag, ".fill_addr_out"}, bus.addr_out, a | VBIT);
    chk({tag, ".fill_ready"}, bus.cache_ready, 1'b1);
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] a);
    issue(a, 1'b0);
    chk({tag, ".hit_dv"}, bus.data_valid, 1'b1);
    chk({tag, ".hit_data"}, bus.data, a ^ K);
    chk({tag, ".hit_addr_out"}, bus.addr_out, a | VBIT);
    chk({tag, ".hit_ready"}, bus.cache_ready, 1'b1);
    chk({tag, ".hit_no_l2"}, bus.addr_to_l2_valid, 1'b0);
  endtask

  initial begin
    bus.addr = '0; bus.addr_vir = '0; bus.addr_valid = 1'b0;
    bus.page_fault = 1'b0; bus.access_fault = 1'b0; bus.flush = 1'b0;
    bus.dcache_flushing = 1'b0; bus.data_from_l2 = '0; bus.data_from_l2_valid = 1'b0;

    // reset values
    repeat (2) smp();
    chk("rst.ready", bus.cache_ready, 1'b1);
    chk("rst.dv", bus.data_valid, 1'b0);
    chk("rst.data", bus.data, 32'h0);
    chk("rst.l2_valid", bus.addr_to_l2_valid, 1'b0);
    chk("rst.l2_addr", bus.addr_to_l2, 26'h0);
    chk("rst.pf_out", bus.page_fault_out, 1'b0);
    rst = 1'b0;
    cyc();
    smp();

    // cold miss then a hit in the freshly filled line
    fetch_miss("cold", 32'h0000_1000);
    fetch_hit("cold_hit", 32'h0000_1004);

    // four ways of set 0, round-robin eviction of way 0 then way 1
    fetch_miss("set0_t0", 32'h0000_0000);
    fetch_miss("set0_t1", 32'h0000_2000);
    fetch_miss("set0_t2", 32'h0000_4000);
    fetch_miss("set0_t3", 32'h0000_6000);
    fetch_hit("rd_t0", 32'h0000_0008);
    fetch_hit("rd_t1", 32'h0000_2008);
    fetch_hit("rd_t2", 32'h0000_4008);
    fetch_hit("rd_t3", 32'h0000_6008);
    fetch_miss("set0_t4", 32'h0000_8000);
    fetch_miss("evicted_t0", 32'h0000_0000);
    fetch_hit("kept_t2", 32'h0000_4000);
    fetch_hit("kept_t4", 32'h0000_8004);

    // streaming hits with the request held
    for (int i = 0; i < 16; i++) begin
      bus.addr       = 32'h0000_1000 + 32'(i * 4);
      bus.addr_vir   = bus.addr | VBIT;
      bus.addr_valid = 1'b1;
      cyc();
      smp();
      chk("stream.ready", bus.cache_ready, 1'b1);
      chk("stream.dv", bus.data_valid, 1'b1);
      chk("stream.data", bus.data, (32'h0000_1000 + 32'(i * 4)) ^ K);
      chk("stream.addr_out", bus.addr_out, (32'h0000_1000 + 32'(i * 4)) | VBIT);
    end
    bus.addr_valid = 1'b0;

    // page fault forwarded as a zero-data hit
    issue(32'h0000_2000, 1'b1);
    chk("fault.dv", bus.data_valid, 1'b1);
    chk("fault.data", bus.data, 32'h0);
    chk("fault.pf_out", bus.page_fault_out, 1'b1);
    chk("fault.af_out", bus.access_fault_out, 1'b0);
    chk("fault.addr_out", bus.addr_out, 32'h0000_2000 | VBIT);
    chk("fault.no_l2", bus.addr_to_l2_valid, 1'b0);
    cyc();
    smp();
    chk("fault.no_l2_after", bus.addr_to_l2_valid, 1'b0);

    // flush while waiting on L2
    issue(32'h0000_3000, 1'b0);
    chk("fw.miss_ready", bus.cache_ready, 1'b0);
    wait_pulse("fw", 32'h0000_3000);
    cyc();
    bus.flush = 1'b1;
    smp();
    chk("fw.ready_in_wait", bus.cache_ready, 1'b0);
    cyc();
    bus.flush = 1'b0;
    smp();
    cyc();
    bus.data_from_l2       = line_for(26'h0C0);
    bus.data_from_l2_valid = 1'b1;
    smp();
    cyc();
    bus.data_from_l2_valid = 1'b0;
    smp();
    chk("fw.no_dv", bus.data_valid, 1'b0);
    chk("fw.idle_ready", bus.cache_ready, 1'b1);
    fetch_miss("fw_again", 32'h0000_3000);
    fetch_miss("fw_flushed", 32'h0000_1000);

    // flush together with a request in idle
    cyc();
    smp();
    bus.addr = 32'h0000_3000; bus.addr_vir = 32'h0000_3000 | VBIT;
    bus.addr_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("fa.ready", bus.cache_ready, 1'b0);
    cyc();
    bus.addr_valid = 1'b0;
    bus.flush = 1'b0;
    smp();
    chk("fa.no_dv", bus.data_valid, 1'b0);
    chk("fa.ready_after", bus.cache_ready, 1'b1);
    fetch_miss("fa_flushed", 32'h0000_3000);

    // D-cache writeback holds off the L2 request
    cyc();
    smp();
    bus.dcache_flushing = 1'b1;
    issue(32'h0000_5000, 1'b0);
    chk("dcf.ready", bus.cache_ready, 1'b0);
    chk("dcf.no_pulse0", bus.addr_to_l2_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk("dcf.no_pulse", bus.addr_to_l2_valid, 1'b0);
    end
    cyc();
    bus.dcache_flushing = 1'b0;
    smp();
    chk("dcf.pulse", bus.addr_to_l2_valid, 1'b1);
    chk("dcf.l2_addr", bus.addr_to_l2, 26'h140);
    cyc();
    smp();
    chk("dcf.pulse_once", bus.addr_to_l2_valid, 1'b0);

    // reset while waiting; stale reply must be ignored
    rst = 1'b1;
    #1;
    chk("rw.ready", bus.cache_ready, 1'b1);
    chk("rw.dv", bus.data_valid, 1'b0);
    chk("rw.l2_valid", bus.addr_to_l2_valid, 1'b0);
    chk("rw.l2_addr", bus.addr_to_l2, 26'h0);
    chk("rw.data", bus.data, 32'h0);
    cyc();
    rst = 1'b0;
    bus.data_from_l2       = line_for(26'h140);
    bus.data_from_l2_valid = 1'b1;
    cyc();
    bus.data_from_l2_valid = 1'b0;
    smp();
    chk("rw.stale_dv", bus.data_valid, 1'b0);
    chk("rw.stale_ready", bus.cache_ready, 1'b1);
    issue(32'h0000_5000, 1'b0);
    chk("rw.miss_again", bus.cache_ready, 1'b0);
    cyc();
    smp();
    chk("rw.pulse_again", bus.addr_to_l2_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
